tl_demand_scheduler: RTL

- Demand scheduler that sits in front of `trafficlight` and drives its AS/BS sensor inputs.
- Merges vehicle sensors, latched pedestrian buttons and emergency-vehicle preemption for roads A and B into the two demand lines.
- Enforces a maximum-green fairness limit by reading back the controller's 2-bit state.
- State encoding: 00 = A green, 01 = A yellow, 10 = B green, 11 = B yellow.

---
 rtl/tl_pkg.sv | 22 ++
 rtl/tl_demand_scheduler_if.sv | 36 +++
 rtl/tl_ped_latch.sv | 75 +++++++
 rtl/tl_demand_scheduler.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light demand scheduler: the encoding of
// the trafficlight state read back from the controller and the scheduler FSM
// state type.
package tl_pkg;

    // Controller state as fed back on tl_state.
    localparam logic [1:0] TL_A_GRN = 2'b00;
    localparam logic [1:0] TL_A_YEL = 2'b01;
    localparam logic [1:0] TL_B_GRN = 2'b10;
    localparam logic [1:0] TL_B_YEL = 2'b11;

    // Scheduler modes: normal demand merging, emergency preemption per road,
    // and the post-preemption hold per road.
    typedef enum logic [2:0] {
        NORMAL = 3'd0,
        EMG_A  = 3'd1,
        EMG_B  = 3'd2,
        HOLD_A = 3'd3,
        HOLD_B = 3'd4
    } sched_state_e;

endpackage

// File: rtl/tl_demand_scheduler_if.sv
// Signal bundle between the sensor/controller side and tl_demand_scheduler.
// Bus semantics (no valid/ready handshake on this bus): veh_x and emg_x are
// levels sampled every rising clock edge; ped_x is a single-cycle pulse that
// counts only on the edge where it is high; tl_state is the controller's
// current state. All scheduler outputs are registered and change only on a
// rising edge (or immediately on reset). dbg_state mirrors the scheduler FSM.
interface tl_demand_scheduler_if;
    import tl_pkg::*;

    logic         veh_a;
    logic         veh_b;
    logic         ped_a;
    logic         ped_b;
    logic         emg_a;
    logic         emg_b;
    logic [1:0]   tl_state;
    logic         AS;
    logic         BS;
    logic         ped_a_wait;
    logic         ped_b_wait;
    logic         emg_active;
    sched_state_e dbg_state;

    // Sensor / controller side.
    modport master (
        output veh_a, veh_b, ped_a, ped_b, emg_a, emg_b, tl_state,
        input  AS, BS, ped_a_wait, ped_b_wait, emg_active, dbg_state
    );

    // Scheduler side.
    modport slave (
        input  veh_a, veh_b, ped_a, ped_b, emg_a, emg_b, tl_state,
        output AS, BS, ped_a_wait, ped_b_wait, emg_active, dbg_state
    );

endinterface

// File: rtl/tl_ped_latch.sv
// Pedestrian request latch for one road. A button pulse sets the latch, the
// first cycle the road shows green clears it (clear beats a simultaneous
// pulse). With TL_PED_PRIORITY_EN defined a wait counter runs while the
// request is pending and raises timeout_o at PED_MAX_WAIT.
module tl_ped_latch
`ifdef TL_PED_PRIORITY_EN
#(
    parameter int CNT_W        = 6,
    parameter int PED_MAX_WAIT = 20
)
`endif
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ped_i,
    input  logic green_i,
    output logic wait_o,
    output logic wait_next_o,
    output logic timeout_o
);

    logic wait_q;
    logic wait_d;

    // Next latch value: own green clears, otherwise a pulse sets.
    always_comb begin
        wait_d = wait_q;
        if (green_i) begin
            wait_d = 1'b0;
        end else if (ped_i) begin
            wait_d = 1'b1;
        end
    end

    // Latch register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign wait_o      = wait_q;
    assign wait_next_o = wait_d;

`ifdef TL_PED_PRIORITY_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wait counter: counts pending cycles, saturates, clears with the latch.
    always_comb begin
        cnt_d = cnt_q;
        if (!wait_d) begin
            cnt_d = '0;
        end else if (wait_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Wait counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = wait_q && (cnt_q >= CNT_W'(PED_MAX_WAIT));
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/tl_demand_scheduler.sv
// Demand scheduler in front of trafficlight: merges vehicle sensors, latched
// pedestrian requests and emergency preemption into the AS/BS demand lines,
// and forces a switch after MAX_GREEN green cycles when the other road waits.
// Optional macro TL_PED_PRIORITY_EN: a pedestrian waiting PED_MAX_WAIT cycles
// forces the opposing green to end regardless of the green counter.
module tl_demand_scheduler
    import tl_pkg::*;
#(
    parameter int CNT_W     = 6,
    parameter int MAX_GREEN = 30,
    parameter int EMG_HOLD  = 8
`ifdef TL_PED_PRIORITY_EN
    , parameter int PED_MAX_WAIT = 20
`endif
) (
    input logic                  CLK,
    input logic                  RSTn,
    tl_demand_scheduler_if.slave sif
);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] green_cnt_q, green_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]       prev_state_q;
    logic             force_a_q, force_a_d, force_b_q, force_b_d;
    logic             as_q, as_d, bs_q, bs_d, emg_q, emg_d;
    logic             ped_a_wait, ped_a_wait_d, ped_a_to;
    logic             ped_b_wait, ped_b_wait_d, ped_b_to;
    logic             green_a, green_b, dem_a, dem_b;

    assign green_a = (sif.tl_state == TL_A_GRN);
    assign green_b = (sif.tl_state == TL_B_GRN);

    tl_ped_latch
`ifdef TL_PED_PRIORITY_EN
        #(.CNT_W(CNT_W), .PED_MAX_WAIT(PED_MAX_WAIT))
`endif
    u_ped_a (
        .clk_i(CLK), .rst_ni(RSTn), .ped_i(sif.ped_a), .green_i(green_a),
        .wait_o(ped_a_wait), .wait_next_o(ped_a_wait_d), .timeout_o(ped_a_to)
    );

    tl_ped_latch
`ifdef TL_PED_PRIORITY_EN
        #(.CNT_W(CNT_W), .PED_MAX_WAIT(PED_MAX_WAIT))
`endif
    u_ped_b (
        .clk_i(CLK), .rst_ni(RSTn), .ped_i(sif.ped_b), .green_i(green_b),
        .wait_o(ped_b_wait), .wait_next_o(ped_b_wait_d), .timeout_o(ped_b_to)
    );

    // Raw demand uses the latch's next value so a pulse shows on AS/BS at the
    // same edge as on ped_x_wait.
    assign dem_a = sif.veh_a | ped_a_wait_d;
    assign dem_b = sif.veh_b | ped_b_wait_d;

    // Green counter: restarts at every controller state change, counts green.
    always_comb begin
        green_cnt_d = green_cnt_q;
        if (sif.tl_state != prev_state_q) begin
            green_cnt_d = '0;
        end else if ((green_a || green_b) && (green_cnt_q != '1)) begin
            green_cnt_d = green_cnt_q + CNT_W'(1);
        end
    end

    // Scheduler FSM next state and hold counter. During a hold only the held
    // road's own request re-enters preemption; the other road waits for expiry.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            NORMAL: begin
                hold_cnt_d = '0;
                if (sif.emg_a)      state_d = EMG_A;
                else if (sif.emg_b) state_d = EMG_B;
            end
            EMG_A, EMG_B: begin
                hold_cnt_d = '0;
                if ((state_q == EMG_A) && !sif.emg_a) begin
                    state_d    = HOLD_A;
                    hold_cnt_d = CNT_W'(1);
                end else if ((state_q == EMG_B) && !sif.emg_b) begin
                    state_d    = HOLD_B;
                    hold_cnt_d = CNT_W'(1);
                end
            end
            HOLD_A, HOLD_B: begin
                if ((state_q == HOLD_A) && sif.emg_a) begin
                    state_d    = EMG_A;
                    hold_cnt_d = '0;
                end else if ((state_q == HOLD_B) && sif.emg_b) begin
                    state_d    = EMG_B;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q >= CNT_W'(EMG_HOLD)) begin
                    hold_cnt_d = '0;
                    if (sif.emg_b)      state_d = EMG_B;
                    else if (sif.emg_a) state_d = EMG_A;
                    else                state_d = NORMAL;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    // Force flags (cleared outside NORMAL and outside their green) and the
    // next values of the registered outputs.
    always_comb begin
        force_a_d = 1'b0;
        force_b_d = 1'b0;
        as_d      = 1'b0;
        bs_d      = 1'b0;
        emg_d     = 1'b0;
        if (state_d == NORMAL) begin
            force_a_d = green_a && (force_a_q || ped_b_to ||
                        ((green_cnt_d >= CNT_W'(MAX_GREEN)) && dem_b));
            force_b_d = green_b && (force_b_q || ped_a_to ||
                        ((green_cnt_d >= CNT_W'(MAX_GREEN)) && dem_a));
        end
        case (state_d)
            EMG_A, HOLD_A: begin
                as_d  = 1'b1;
                emg_d = 1'b1;
            end
            EMG_B, HOLD_B: begin
                bs_d  = 1'b1;
                emg_d = 1'b1;
            end
            default: begin
                as_d = dem_a & ~force_a_d;
                bs_d = dem_b & ~force_b_d;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= NORMAL;
            green_cnt_q  <= '0;
            hold_cnt_q   <= '0;
            prev_state_q <= TL_A_GRN;
            force_a_q    <= 1'b0;
            force_b_q    <= 1'b0;
            as_q         <= 1'b0;
            bs_q         <= 1'b0;
            emg_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            green_cnt_q  <= green_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            prev_state_q <= sif.tl_state;
            force_a_q    <= force_a_d;
            force_b_q    <= force_b_d;
            as_q         <= as_d;
            bs_q         <= bs_d;
            emg_q        <= emg_d;
        end
    end

    assign sif.AS         = as_q;
    assign sif.BS         = bs_q;
    assign sif.ped_a_wait = ped_a_wait;
    assign sif.ped_b_wait = ped_b_wait;
    assign sif.emg_active = emg_q;
    assign sif.dbg_state  = state_q;

endmodule
